roundkey_store: RTL

ROUNDKEY_STORE -- requirements
Module: roundkey_store

---
 rtl/aes_dec_pkg.sv | 6 +
 rtl/rkey_regfile.sv | 19 +
 rtl/roundkey_store.sv | 58 +++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES decrypt round-key path
package aes_dec_pkg;
  typedef logic [0:127] roundkey_t;
  typedef enum logic [1:0] {EMPTY, LOAD, READY} rks_state_t;
  localparam int NKEYS_192 = 13;
endpackage

// File: rtl/rkey_regfile.sv
// rkey_regfile: NKEYS round-key slots, one write port, one asynchronous read port
module rkey_regfile
  import aes_dec_pkg::*;
#(
  parameter int NKEYS = NKEYS_192,
  parameter int AW = $clog2(NKEYS + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  roundkey_t     wdata,
  input  logic [AW-1:0] raddr,
  output roundkey_t     rdata
);
  roundkey_t mem [NKEYS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/roundkey_store.sv
// roundkey_store: stores a forward key schedule and plays it back in reverse; RKSTORE_ERRCHK_EN adds length checking
module roundkey_store
  import aes_dec_pkg::*;
#(
  parameter int NKEYS = NKEYS_192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] rkey_in,
  input  logic         rkey_in_vld,
  input  logic         rkey_in_last,
  output logic         ks_rdy,
  input  logic         rk_adv,
  output logic [0:127] rkey_out,
  output logic         rk_first,
  output logic         rk_last,
  output logic         key_err
);
  localparam int PW = $clog2(NKEYS + 1);
  localparam logic [PW-1:0] TOP = PW'(NKEYS - 1);
  localparam logic [PW-1:0] FULL = PW'(NKEYS);
  rks_state_t state;
  logic [PW-1:0] wr_ptr, rd_ptr, waddr;
  logic start, we;
  roundkey_t rd_key;
  assign start = rkey_in_vld && state != LOAD;
  assign we = rkey_in_vld && (start || wr_ptr != FULL);
  assign waddr = start ? '0 : wr_ptr;
  rkey_regfile #(.NKEYS(NKEYS), .AW(PW)) u_rf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(rkey_in), .raddr(rd_ptr), .rdata(rd_key)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ks_rdy <= 1'b0;
    end else if (rkey_in_vld) begin
      state <= rkey_in_last ? READY : LOAD;
      ks_rdy <= rkey_in_last;
      wr_ptr <= we ? waddr + PW'(1) : wr_ptr;
      if (rkey_in_last) rd_ptr <= we ? waddr : TOP;
    end else if (state == READY && rk_adv)
      rd_ptr <= rd_ptr == '0 ? TOP : rd_ptr - PW'(1);
  assign rkey_out = ks_rdy ? rd_key : '0;
  assign rk_first = ks_rdy && rd_ptr == TOP;
  assign rk_last = ks_rdy && rd_ptr == '0;
`ifdef RKSTORE_ERRCHK_EN
  logic err;
  // a dropped overflow write, or a last key landing anywhere but the top slot, is a bad schedule
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (rkey_in_vld && (rkey_in_last ? waddr != TOP : !we)) err <= 1'b1;
  assign key_err = err;
`else
  assign key_err = 1'b0;
`endif
endmodule
